packet_rr_arbiter: RTL and testbench
====================================

// Module: packet_rr_arbiter
// PURPOSE
// - Packet-level round-robin arbiter for N requesters sharing one downstream resource.
// - A winner keeps its grant for a whole packet, i.e. until it pulses its fin bit.
// - Only then is the next requester selected, in rotating priority order.
// - Sits between N packet sources and a single shared sink; the sink gates new grants via ready.
// PARAMETERS
// - N  default 4  number of requesters (>=2); sets the width of req/fin/grant
// PORTS
// - clock  in   1  single clock; all logic updates on its rising edge
// - reset  in   1  synchronous, active-high reset
// - req    in   N  per-requester request; level, held while the packet waits
// - fin    in   N  per-requester end-of-packet pulse; honoured only for the granted index
// - ready  in   1  sink can accept a new packet; gates new arbitration only
// - grant  out  N  registered one-hot (or all-zero) grant vector
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - State: IDLE (grant==0) and BUSY (one grant bit set); last-winner pointer ptr.
// - Reset: grant=0, state=IDLE, ptr=N-1, so requester 0 has top priority after reset.
// - Reset mid-packet drops grant to 0 at that edge.
// - IDLE -> BUSY: at a rising edge with ready==1 and |req, grant[w]<=1.
//   - w is the first set req index searching ptr+1, ptr+2, ... with wrap modulo N.
//   - ptr<=w.
//   - Latency: req sampled at edge k -> grant visible after edge k (1 cycle).
// - IDLE with ready==0 or req==0: grant stays 0 and ptr is unchanged.
// - BUSY: grant is held constant regardless of req, ready or other fin bits.
// - BUSY -> IDLE: at the edge where fin[w]==1, grant<=0.
//   - The next grant is issued no earlier than the following edge.
//   - This gives exactly one idle cycle between packets when others are waiting.
// - fin on a non-granted index, or fin while IDLE: ignored.
// - req[w] dropping before fin[w]: grant is still held until fin[w] (packet semantics).
// - Simultaneous fin[w] and req[w] still high: w is re-arbitrated next time.
//   - w now has lowest priority (ptr==w), so any other requester wins first.
// - Lone requester: it is granted again even if it is ptr (wrap search includes ptr last).
// - Invariant: $onehot0(grant) every cycle.
// - Invariant: grant changes only on rising edges.
// TESTING
// - Reset 5 cycles with req=4'hF: grant stays 0 throughout reset.
//   - After release with ready=1: grant=4'b0001 one edge later.
// - All four req set at once, each requester asserts fin 5 cycles after its grant:
//   - grant sequence 0001,0000,0010,0000,0100,0000,1000, then 0.
// - req=4'b0101 after requester 0's packet ends: next grant=4'b0100 (skips idle 1).
//   - Following grant=4'b0001 on wrap.
// - ready=0 with req=4'b0010: grant stays 0; ready->1 gives grant=4'b0010 next edge.
//   - Dropping ready mid-packet does not remove the grant.
// - While grant=4'b0001: pulse fin=4'b0010 -> ignored, grant holds.
//   - Then drop req[0] without fin -> grant still 4'b0001 until fin[0].
// - Single requester 3 repeats packets: grant=4'b1000 for each packet.
//   - One zero-grant cycle after every fin[3].

Source files
------------

// File: rtl/packet_rr_arbiter.sv
// Packet-level round-robin arbiter: a winner holds its grant until it pulses its own fin bit,
// then the next requester is picked starting just after the last winner.
module packet_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] fin_i,
    input  logic         ready_i,
    output logic [N-1:0] grant_o
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q;
    logic [PtrW-1:0] ptr_q;
    logic [N-1:0]    grant_q;

    logic            win_valid;
    logic [PtrW-1:0] win_idx;
    int unsigned     cand;

    // Search ptr+1 .. ptr+N so the last winner is considered last, not skipped.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_q;
        cand      = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(ptr_q) + i) % N;
            if (!win_valid && req_i[PtrW'(cand)]) begin
                win_valid = 1'b1;
                win_idx   = PtrW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= PtrW'(N - 1);
            grant_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ready_i && win_valid) begin
                        grant_q <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        ptr_q   <= win_idx;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Only the granted index may end the packet.
                    if (|(fin_i & grant_q)) begin
                        grant_q <= '0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter: one task per scenario, expected grants hand-derived.
module tb_packet_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] fin;
    logic       ready;
    logic [3:0] grant;

    int total = 0;
    int bad   = 0;

    packet_rr_arbiter #(.N(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .fin_i   (fin),
        .ready_i (ready),
        .grant_o (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 4'b0000;
        fin   = 4'b0000;
        ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 4'hF;
        fin   = 4'b0000;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, grant);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_release got=%b want=0001", grant);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp;
        do_reset();
        req = 4'hF;
        tick();
        for (int w = 0; w < 4; w++) begin
            exp = 4'b0001 << w;
            for (int c = 0; c < 5; c++) begin
                total++;
                if (grant !== exp) begin
                    bad++;
                    $display("FAIL all_four_hold w=%0d c=%0d got=%b want=%b", w, c, grant, exp);
                end
                if (c < 4) tick();
            end
            fin = exp;
            req = req & ~exp;
            tick();
            fin = 4'b0000;
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL all_four_gap w=%0d got=%b want=0000", w, grant);
            end
            tick();
        end
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL all_four_end got=%b want=0000", grant);
        end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req = 4'b0001;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL skip_first got=%b want=0001", grant);
        end
        req = 4'b0101;
        fin = 4'b0001;
        tick();
        fin = 4'b0000;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL skip_gap got=%b want=0000", grant);
        end
        tick();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL skip_idle1 got=%b want=0100", grant);
        end
        fin = 4'b0100;
        tick();
        fin = 4'b0000;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL wrap_gap got=%b want=0000", grant);
        end
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_grant got=%b want=0001", grant);
        end
        req = 4'b0000;
        fin = 4'b0001;
        tick();
        fin = 4'b0000;
    endtask

    task automatic test_ready();
        do_reset();
        ready = 1'b0;
        req   = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL ready_low cyc=%0d got=%b want=0000", i, grant);
            end
        end
        ready = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL ready_rise got=%b want=0010", grant);
        end
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (grant !== 4'b0010) begin
                bad++;
                $display("FAIL ready_drop_busy cyc=%0d got=%b want=0010", i, grant);
            end
        end
        fin = 4'b0010;
        req = 4'b0000;
        tick();
        fin   = 4'b0000;
        ready = 1'b1;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL ready_fin got=%b want=0000", grant);
        end
    endtask

    task automatic test_ignore_fin();
        do_reset();
        req = 4'b0001;
        tick();
        fin = 4'b0010;
        tick();
        fin = 4'b0000;
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL foreign_fin got=%b want=0001", grant);
        end
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (grant !== 4'b0001) begin
                bad++;
                $display("FAIL req_drop_hold cyc=%0d got=%b want=0001", i, grant);
            end
        end
        fin = 4'b0001;
        tick();
        fin = 4'b0000;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL own_fin got=%b want=0000", grant);
        end
        fin = 4'b0100;
        tick();
        fin = 4'b0000;
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL idle_fin got=%b want=0000", grant);
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req = 4'b1000;
        tick();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 2; c++) begin
                total++;
                if (grant !== 4'b1000) begin
                    bad++;
                    $display("FAIL single_hold p=%0d c=%0d got=%b want=1000", p, c, grant);
                end
                tick();
            end
            fin = 4'b1000;
            tick();
            fin = 4'b0000;
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL single_gap p=%0d got=%b want=0000", p, grant);
            end
            tick();
        end
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL single_regrant got=%b want=1000", grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        rst = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid got=%b want=0000", grant);
        end
        rst = 1'b0;
        req = 4'b1010;
        tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL reset_ptr got=%b want=0010", grant);
        end
        req = 4'b0000;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        fin   = 4'b0000;
        ready = 1'b0;
        test_reset();
        test_all_four();
        test_skip_wrap();
        test_ready();
        test_ignore_fin();
        test_single_requester();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
